// File: rtl/mem_responder.sv
// Single-request load/store responder in front of a synchronous BRAM.
// Handles lane steering, extension, alignment and range checks.
module mem_responder #(
  parameter int ADDR_W       = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [2:0]        req_funct3_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [1:0] LAST = 2'(READ_LATENCY - 1);

  state_t state, next;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [1:0]        cnt;

  logic        accept;
  logic        last;
  logic        range_err;
  logic        f3_err;
  logic        align_err;
  logic        err;
  logic [1:0]  size;
  logic [3:0]  mask;
  logic [31:0] steer;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        sext;
  logic [31:0] ext;

  assign accept = req_valid_i & (state == IDLE);
  assign last   = (cnt == LAST);
  assign size   = req_funct3_i[1:0];

  assign range_err = |(req_addr_i >> (ADDR_W + 2));
  assign f3_err = req_we_i
    ? (req_funct3_i > 3'b010)
    : (req_funct3_i == 3'b011) | (req_funct3_i[2:1] == 2'b11);
  assign align_err = ((size == 2'b01) & req_addr_i[0])
                   | ((size == 2'b10) & (|req_addr_i[1:0]));
  assign err = range_err | f3_err | align_err;

  always_comb begin
    mask  = 4'b1111;
    steer = req_wdata_i;
    unique case (1'b1)
      size == 2'b00: begin
        mask  = 4'b0001 << req_addr_i[1:0];
        steer = {4{req_wdata_i[7:0]}};
      end
      size == 2'b01: begin
        mask  = req_addr_i[1] ? 4'b1100 : 4'b0011;
        steer = {2{req_wdata_i[15:0]}};
      end
      default: begin
        mask  = 4'b1111;
        steer = req_wdata_i;
      end
    endcase
  end

  assign rbyte = 8'(mem_rdata_i >> {off_q, 3'b000});
  assign rhalf = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
  assign sext  = ~f3_q[2];

  always_comb begin
    ext = mem_rdata_i;
    unique case (1'b1)
      f3_q[1:0] == 2'b00: ext = {{24{sext & rbyte[7]}}, rbyte};
      f3_q[1:0] == 2'b01: ext = {{16{sext & rhalf[15]}}, rhalf};
      default:            ext = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state   <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= next;
      if (accept) begin
        addr_q  <= req_addr_i[ADDR_W+1:2];
        off_q   <= req_addr_i[1:0];
        f3_q    <= req_funct3_i;
        we_q    <= req_we_i;
        mask_q  <= req_we_i ? mask : 4'b0000;
        wdata_q <= steer;
        err_q   <= err;
        rdata_q <= '0;
      end else if (state == WAIT && last) begin
        rdata_q <= ext;
      end
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT)
        cnt <= cnt + 2'd1;
    end
  end

  always_comb begin
    next        = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (accept)
          next = err ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_en_o    = 1'b1;
        mem_we_o    = mask_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        next        = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (last)
          next = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = rdata_q;
        next        = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two responders (read latency 1 and 3), each with a
// behavioural BRAM; responses and BRAM issues are checked against queues.
module tb_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [11:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    int          cyc;
  } iss_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        v0, we0, rdy0, rv0, re0, en0;
  logic [31:0] a0, wd0, rd0, mwd0, mrd0;
  logic [2:0]  f0;
  logic [3:0]  mwe0;
  logic [11:0] ma0;

  logic        v1, we1, rdy1, rv1, re1, en1;
  logic [31:0] a1, wd1, rd1, mwd1, mrd1;
  logic [2:0]  f1;
  logic [3:0]  mwe1;
  logic [11:0] ma1;

  rsp_t rq0[$], rq1[$];
  iss_t iq0[$], iq1[$];

  mem_responder #(.ADDR_W(12), .READ_LATENCY(1)) dut0 (
    .clk_i(clk), .reset_ni(rst_n),
    .req_valid_i(v0), .req_ready_o(rdy0), .req_we_i(we0),
    .req_addr_i(a0), .req_wdata_i(wd0), .req_funct3_i(f0),
    .rsp_valid_o(rv0), .rsp_rdata_o(rd0), .rsp_err_o(re0),
    .mem_en_o(en0), .mem_we_o(mwe0), .mem_addr_o(ma0),
    .mem_wdata_o(mwd0), .mem_rdata_i(mrd0)
  );

  mem_responder #(.ADDR_W(12), .READ_LATENCY(3)) dut1 (
    .clk_i(clk), .reset_ni(rst_n),
    .req_valid_i(v1), .req_ready_o(rdy1), .req_we_i(we1),
    .req_addr_i(a1), .req_wdata_i(wd1), .req_funct3_i(f1),
    .rsp_valid_o(rv1), .rsp_rdata_o(rd1), .rsp_err_o(re1),
    .mem_en_o(en1), .mem_we_o(mwe1), .mem_addr_o(ma1),
    .mem_wdata_o(mwd1), .mem_rdata_i(mrd1)
  );

  logic [31:0] ram0[4096];
  logic [31:0] ram1[4096];
  logic [31:0] p0;
  logic [31:0] p1[3];

  always @(posedge clk) begin
    if (en0) begin
      for (int b = 0; b < 4; b++)
        if (mwe0[b]) ram0[ma0][8*b+:8] <= mwd0[8*b+:8];
      p0 <= ram0[ma0];
    end
  end

  always @(posedge clk) begin
    if (en1) begin
      for (int b = 0; b < 4; b++)
        if (mwe1[b]) ram1[ma1][8*b+:8] <= mwd1[8*b+:8];
      p1[0] <= ram1[ma1];
    end
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end

  assign mrd0 = p0;
  assign mrd1 = p1[2];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mon_rsp(input int d, input logic v,
                         input logic [31:0] rd, input logic er);
    rsp_t e;
    int   sz;
    if (!v) return;
    sz = (d == 0) ? rq0.size() : rq1.size();
    if (sz == 0) begin
      check($sformatf("d%0d_rsp_spurious", d), 32'(v), 32'd0);
      return;
    end
    if (d == 0) e = rq0.pop_front();
    else        e = rq1.pop_front();
    check($sformatf("d%0d_rdata", d), rd, e.rdata);
    check($sformatf("d%0d_err", d), 32'(er), 32'(e.err));
    check($sformatf("d%0d_rsp_cycle", d), 32'(cyc), 32'(e.cyc));
  endtask

  task automatic mon_iss(input int d, input logic en, input logic [11:0] ma,
                         input logic [3:0] mwe, input logic [31:0] mwd);
    iss_t e;
    int   sz;
    if (!en) return;
    sz = (d == 0) ? iq0.size() : iq1.size();
    if (sz == 0) begin
      check($sformatf("d%0d_en_spurious", d), 32'(en), 32'd0);
      return;
    end
    if (d == 0) e = iq0.pop_front();
    else        e = iq1.pop_front();
    check($sformatf("d%0d_mem_addr", d), 32'(ma), 32'(e.addr));
    check($sformatf("d%0d_mem_we", d), 32'(mwe), 32'(e.we));
    check($sformatf("d%0d_mem_wdata", d), mwd, e.wdata);
    check($sformatf("d%0d_iss_cycle", d), 32'(cyc), 32'(e.cyc));
  endtask

  initial forever begin
    @(negedge clk);
    mon_rsp(0, rv0, rd0, re0);
    mon_rsp(1, rv1, rd1, re1);
    mon_iss(0, en0, ma0, mwe0, mwd0);
    mon_iss(1, en1, ma1, mwe1, mwd1);
  end

  task automatic drive(input int d, input logic v, input logic we,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3);
    if (d == 0) begin
      v0 = v; we0 = we; a0 = a; wd0 = wd; f0 = f3;
    end else begin
      v1 = v; we1 = we; a1 = a; wd1 = wd; f1 = f3;
    end
  endtask

  task automatic send(input int d, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [2:0] f3,
                      input logic [31:0] er, input logic ee,
                      input logic [3:0] ewe, input logic [31:0] ewd,
                      input logic keep, output int t);
    int   n;
    int   lat;
    rsp_t r;
    iss_t i;
    drive(d, 1'b1, we, a, wd, f3);
    n = 0;
    while (!((d == 0) ? rdy0 : rdy1) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    t = cyc;
    if (n >= 50) begin
      check("ready_timeout", 32'((d == 0) ? rdy0 : rdy1), 32'd1);
      drive(d, 1'b0, we, a, wd, f3);
      return;
    end
    lat = ee ? 1 : (we ? 2 : 2 + ((d == 0) ? 1 : 3));
    r.rdata = er; r.err = ee; r.cyc = t + lat;
    i.addr = a[13:2]; i.we = ewe; i.wdata = ewd; i.cyc = t + 1;
    if (d == 0) begin
      rq0.push_back(r);
      if (!ee) iq0.push_back(i);
    end else begin
      rq1.push_back(r);
      if (!ee) iq1.push_back(i);
    end
    @(posedge clk);
    #1;
    if (!keep) drive(d, 1'b0, we, a, wd, f3);
  endtask

  task automatic st(input int d, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input logic [3:0] ewe,
                    input logic [31:0] ewd);
    int t;
    send(d, 1'b1, a, wd, f3, 32'd0, 1'b0, ewe, ewd, 1'b0, t);
  endtask

  task automatic ld(input int d, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] er);
    int t;
    send(d, 1'b0, a, 32'd0, f3, er, 1'b0, 4'b0000, 32'd0, 1'b0, t);
  endtask

  task automatic bad(input int d, input logic we, input logic [2:0] f3,
                     input logic [31:0] a);
    int t;
    send(d, we, a, 32'hFFFF_FFFF, f3, 32'd0, 1'b1, 4'b0, 32'd0, 1'b0, t);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq0.size() + rq1.size() + iq0.size() + iq1.size()) != 0
           && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(rq0.size() + rq1.size() + iq0.size() + iq1.size()),
          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int ta, tb;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp", {29'd0, rv0, re0, en0}, 32'd0);
    check("rst_rdata", rd0, 32'd0);
    check("rst_mem_we", 32'(mwe0), 32'd0);
    check("rst_mem_addr", 32'(ma0), 32'd0);
    check("rst_mem_wdata", mwd0, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rdy0_after_rst", 32'(rdy0), 32'd1);
    check("rdy1_after_rst", 32'(rdy1), 32'd1);
    @(posedge clk);
    #1;

    st(0, 3'b010, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    ld(0, 3'b010, 32'h10, 32'hDEAD_BEEF);
    st(0, 3'b010, 32'h10, 32'h80AA_BBCC, 4'b1111, 32'h80AA_BBCC);
    ld(0, 3'b000, 32'h13, 32'hFFFF_FF80);
    ld(0, 3'b100, 32'h13, 32'h0000_0080);
    ld(0, 3'b001, 32'h12, 32'hFFFF_80AA);
    st(0, 3'b010, 32'h20, 32'h0000_ABCD, 4'b1111, 32'h0000_ABCD);
    st(0, 3'b001, 32'h22, 32'hFFFF_1234, 4'b1100, 32'h1234_1234);
    ld(0, 3'b101, 32'h22, 32'h0000_1234);
    ld(0, 3'b001, 32'h20, 32'hFFFF_ABCD);
    ld(0, 3'b010, 32'h20, 32'h1234_ABCD);
    st(0, 3'b010, 32'h24, 32'h0, 4'b1111, 32'h0);
    st(0, 3'b000, 32'h25, 32'h7777_77A5, 4'b0010, 32'hA5A5_A5A5);
    ld(0, 3'b000, 32'h25, 32'hFFFF_FFA5);
    ld(0, 3'b100, 32'h24, 32'h0000_0000);
    ld(0, 3'b010, 32'h24, 32'h0000_A500);
    st(0, 3'b010, 32'h3FFC, 32'h1357_9BDF, 4'b1111, 32'h1357_9BDF);
    ld(0, 3'b010, 32'h3FFC, 32'h1357_9BDF);

    bad(0, 1'b0, 3'b010, 32'h6);
    bad(0, 1'b0, 3'b010, 32'h4000);
    bad(0, 1'b0, 3'b011, 32'h0);
    bad(0, 1'b0, 3'b110, 32'h0);
    bad(0, 1'b0, 3'b101, 32'h21);
    bad(0, 1'b1, 3'b001, 32'h23);
    bad(0, 1'b1, 3'b100, 32'h10);
    bad(0, 1'b1, 3'b000, 32'h8000_0000);
    ld(0, 3'b010, 32'h10, 32'h80AA_BBCC);
    drain();

    st(1, 3'b010, 32'h8, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    st(1, 3'b010, 32'hC, 32'h0BAD_C0DE, 4'b1111, 32'h0BAD_C0DE);
    send(1, 1'b0, 32'h8, 32'd0, 3'b010, 32'hCAFE_F00D, 1'b0,
         4'b0, 32'd0, 1'b1, ta);
    send(1, 1'b0, 32'hC, 32'd0, 3'b010, 32'h0BAD_C0DE, 1'b0,
         4'b0, 32'd0, 1'b0, tb);
    check("b2b_accept_gap", 32'(tb - ta), 32'd6);
    ld(1, 3'b100, 32'hB, 32'h0000_00CA);
    drain();

    ld(0, 3'b010, 32'h24, 32'h0000_A500);
    drain();

    send(1, 1'b0, 32'h8, 32'd0, 3'b010, 32'hCAFE_F00D, 1'b0,
         4'b0, 32'd0, 1'b0, ta);
    @(posedge clk);
    #1 rst_n = 1'b0;
    rq1.delete();
    @(negedge clk);
    check("mid_rst_rsp", {29'd0, rv1, re1, en1}, 32'd0);
    check("mid_rst_rdata", rd1, 32'd0);
    check("mid_rst_mem", {mwd1 | {16'd0, 4'd0, ma1}}, 32'd0);
    check("mid_rst_we", 32'(mwe1), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 32'(rdy1), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    ld(1, 3'b010, 32'hC, 32'h0BAD_C0DE);
    drain();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle RISC-V core: accepts one load/store request at a time and drives a synchronous single-port BRAM.
- Handles byte/halfword lane steering, sign/zero extension, alignment and range checks.
- Returns exactly one response per accepted request.
- Sits between the core datapath's address/write-data registers and the unified instruction/data BRAM. Instruction fetches use the same path as word loads (funct3=010).

Parameters:
ADDR_W, 12, word-address width of the BRAM port (BRAM depth = 2^ADDR_W words)
READ_LATENCY, 1, cycles from BRAM enable to valid mem_rdata_i; legal range 1..4

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous, active-low reset
req_valid_i  in  1  request present
req_ready_o  out  1  block accepts a request this cycle
req_we_i  in  1  1=store, 0=load
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, right-aligned
req_funct3_i  in  3  RV32I load/store funct3
rsp_valid_o  out  1  one-cycle response strobe
rsp_rdata_o  out  32  extended load data; 0 for stores and errors
rsp_err_o  out  1  request rejected (misaligned, bad funct3, out of range)
mem_en_o  out  1  BRAM enable
mem_we_o  out  4  BRAM byte write enables
mem_addr_o  out  ADDR_W  BRAM word address
mem_wdata_o  out  32  BRAM write data
mem_rdata_i  in  32  BRAM read data

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on reset_ni.
- Reset state: state=IDLE. rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- req_ready_o = (state==IDLE), so it reads 1 once reset deasserts.
- Reset mid-operation: abort immediately, return to IDLE, no response issued.
- Handshake: a request is accepted when req_valid_i & req_ready_o. All request fields are captured at acceptance. req_valid_i in any non-IDLE state is ignored.
- No response backpressure: the core always consumes rsp_valid_o.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE -> RESP on an erroring request. No BRAM access; rsp_err_o=1, rsp_rdata_o=0.
- IDLE -> ISSUE on a valid request.
- ISSUE: for exactly one cycle, mem_en_o=1, mem_addr_o=addr[ADDR_W+1:2], mem_we_o=store mask (0 for loads), mem_wdata_o=steered data. Next state: store -> RESP, load -> WAIT.
- WAIT: lasts READ_LATENCY cycles with an internal counter. mem_rdata_i is sampled on the last WAIT edge, then the FSM goes to RESP.
- RESP: rsp_valid_o=1 for exactly one cycle, then IDLE. mem_en_o and mem_we_o are 0 in every state other than ISSUE.
- Latency, with acceptance in cycle T:
  - error response in T+1
  - store response in T+2
  - load response in T+2+READ_LATENCY
- Error conditions, any of:
  - req_addr_i[31:ADDR_W+2] != 0
  - load funct3 in {011,110,111}
  - store funct3 > 010
  - halfword access with addr[0]=1
  - word access with addr[1:0] != 0
- Store lanes:
  - sb: we = 1<<addr[1:0]; wdata = {4{wdata[7:0]}}
  - sh: we = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}
  - sw: we = 1111; wdata = wdata
- Load extraction from the sampled word:
  - lb/lbu: select byte addr[1:0], sign-/zero-extend
  - lh/lhu: select half addr[1], sign-/zero-extend
  - lw: full word
- Back-to-back: a new request can be accepted in the cycle after RESP (the IDLE cycle). Peak throughput is 1 store per 3 cycles.

Test Plan:
- Reset then sw addr=0x10, wdata=0xDEADBEEF -> in ISSUE: mem_addr_o=4, mem_we_o=1111, mem_wdata_o=0xDEADBEEF; rsp_valid_o=1 at T+2, rsp_err_o=0, rsp_rdata_o=0.
- lb addr=0x13, BRAM word 4 = 0x80AABBCC, READ_LATENCY=1 -> rsp at T+3, rsp_rdata_o=0xFFFFFF80. Same with lbu -> 0x00000080.
- sh addr=0x22, wdata=0x1234 -> mem_we_o=1100, mem_wdata_o=0x12341234. lhu addr=0x22 on word 0x1234ABCD -> 0x00001234.
- lw addr=0x6 -> rsp_err_o=1 at T+1, mem_en_o never asserted. lw addr=0x4000 with ADDR_W=12 -> rsp_err_o=1. Load funct3=011 -> rsp_err_o=1.
- READ_LATENCY=3, lw addr=0x8 -> rsp_valid_o at T+5 with the correct word. req_valid_i held high throughout is not accepted until the cycle after RESP.
- Assert reset_ni=0 during WAIT -> next cycle all outputs at reset values, req_ready_o=1 after release, no rsp_valid_o pulse.
